// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM encoding, frame width and parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } uart_state_e;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick divider for uart_rx: one-cycle tick every DIV clocks, restartable.
module uart_rx_tick #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider next state; restart realigns the phase to the start-bit edge.
    always_comb begin
        if (restart) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, 16x oversampled, one-entry holding register.
// Define UART_RX_PARITY_EN for 8E1/8O1 reception with a parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int IN_FREQ    = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    , output logic     parity_err
`endif
);

    localparam int DIV = IN_FREQ / (BAUD * OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_TOP = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 rx_s, tick_s, restart_s, mid_s, stop_mid_s, good_s, par_fail_s;

    assign rx_s       = rx_sync_q;
    assign restart_s  = (state_q == ST_IDLE) && !rx_s;
    assign mid_s      = tick_s && (samp_q == MID);
    assign stop_mid_s = (state_q == ST_STOP) && mid_s;
    assign good_s     = stop_mid_s && rx_s && !par_fail_s;

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a low stop bit may be a break, so wait for the line to idle again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_IDLE: state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_IDLE:      state_d = rx_s ? ST_IDLE : ST_START;
            ST_START:     state_d = mid_s ? (rx_s ? ST_IDLE : ST_DATA) : ST_START;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      state_d = (mid_s && bit_idx_q == LAST_BIT) ? ST_PARITY : ST_DATA;
            ST_PARITY:    state_d = mid_s ? ST_STOP : ST_PARITY;
`else
            ST_DATA:      state_d = (mid_s && bit_idx_q == LAST_BIT) ? ST_STOP : ST_DATA;
`endif
            ST_STOP:      state_d = mid_s ? (rx_s ? ST_IDLE : ST_WAIT_IDLE) : ST_STOP;
            default:      state_d = ST_WAIT_IDLE;
        endcase
    end

    // FSM outputs and datapath next state.
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        if (restart_s) begin
            samp_d = {SW{1'b0}};
        end else if (tick_s) begin
            samp_d = (samp_q == SAMP_TOP) ? {SW{1'b0}} : samp_q + SW'(1);
        end else begin
            samp_d = samp_q;
        end
        if ((state_q == ST_START) && mid_s) begin
            bit_idx_d = 3'd0;
            shift_d   = shift_q;
        end else if ((state_q == ST_DATA) && mid_s) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
        end else begin
            bit_idx_d = bit_idx_q;
            shift_d   = shift_q;
        end
        frame_err_d = stop_mid_s && !rx_s;
        overrun_d   = good_s && valid_q && !ready;
        if (good_s && (!valid_q || ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            data_d  = data_q;
            valid_d = 1'b0;
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Synchronizer, datapath and registered outputs; sync resets low so WAIT_IDLE must see a real high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
            samp_q      <= {SW{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= {DATA_BITS{1'b0}};
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d, parity_err_q, parity_err_d;

    // Parity verdict is held until the stop bit so a framing error can override it.
    always_comb begin
        if ((state_q == ST_START) && mid_s) begin
            par_bad_d = 1'b0;
        end else if ((state_q == ST_PARITY) && mid_s) begin
            par_bad_d = (rx_s != parity_bit(shift_q, PARITY_ODD));
        end else begin
            par_bad_d = par_bad_q;
        end
        parity_err_d = stop_mid_s && rx_s && par_bad_q;
    end

    // Parity registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign par_fail_s = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_fail_s = 1'b0;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

    localparam int IN_FREQ    = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = IN_FREQ / BAUD;
    localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy, parity_err;

    uart_rx #(
        .IN_FREQ    (IN_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
        , .PARITY_ODD (PARITY_ODD)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        , .parity_err (parity_err)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Observed activity, sampled on the falling edge.
    int         cyc = 0;
    int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, wide_cnt = 0;
    int         unstable_cnt = 0, drop_cnt = 0, vhigh_cnt = 0, rise_cyc = 0;
    logic [7:0] acc_q[$];
    logic       valid_p = 1'b0, acc_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, pe_p = 1'b0, reset_p = 1'b1;
    logic [7:0] data_p = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid && ready) acc_q.push_back(data);
        if (valid) vhigh_cnt <= vhigh_cnt + 1;
        if (valid && !valid_p) rise_cyc <= cyc;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if ((frame_err && fe_p) || (overrun && ov_p) || (parity_err && pe_p)) wide_cnt <= wide_cnt + 1;
        if (valid_p && !acc_p && valid && (data != data_p)) unstable_cnt <= unstable_cnt + 1;
        if (valid_p && !acc_p && !valid && !reset && !reset_p) drop_cnt <= drop_cnt + 1;
        valid_p <= valid;
        acc_p   <= valid && ready;
        fe_p    <= frame_err;
        ov_p    <= overrun;
        pe_p    <= parity_err;
        reset_p <= reset;
        data_p  <= data;
    end

    // Frame-level reference model.
    logic [7:0] exp_acc[$];
    int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
    logic       exp_full = 1'b0;
    logic [7:0] exp_hold = 8'h00;
    int         stop_cyc = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        if (!stop) exp_fe++;
        else if (PAR_EN && par_flip) exp_pe++;
        else if (ready) exp_acc.push_back(b);
        else if (!exp_full) begin exp_full = 1'b1; exp_hold = b; end
        else exp_ov++;
    endtask

    task automatic model_release();
        if (exp_full) begin
            exp_acc.push_back(exp_hold);
            exp_full = 1'b0;
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    // Leaves rx at the stop-bit level; a good stop is followed by a short idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        if (PAR_EN) bit_time((^b) ^ PARITY_ODD ^ par_flip);
        stop_cyc = cyc;
        bit_time(stop);
        model_frame(b, stop, par_flip);
        if (stop) repeat (20) @(negedge clock);
    endtask

    task automatic check_all(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
            if (acc_q[i] !== exp_acc[i]) mism++;
        chk({tag, "/accepted"}, acc_q.size(), exp_acc.size());
        chk({tag, "/bytes"}, mism, 0);
        chk({tag, "/frame_err"}, fe_cnt, exp_fe);
        chk({tag, "/overrun"}, ov_cnt, exp_ov);
        chk({tag, "/parity_err"}, pe_cnt, exp_pe);
        chk({tag, "/pulse_width"}, wide_cnt, 0);
        chk({tag, "/hold_stable"}, unstable_cnt + drop_cnt, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/data"}, int'(data), 0);
        chk({tag, "/valid"}, int'(valid), 0);
        chk({tag, "/flags"}, int'({frame_err, overrun, parity_err}), 0);
        chk({tag, "/busy"}, int'(busy), 1);
    endtask

    initial begin
        logic [7:0] b;
        logic       st, pf;

        // 1: reset values, idle, then 0xA5 with a single valid cycle
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("idle/busy", int'(busy), 0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check_all("t1");
        chk("t1/valid_cycles", vhigh_cnt, 1);
        chk("t1/latency_ok", int'((rise_cyc - stop_cyc) >= 76 && (rise_cyc - stop_cyc) <= 92), 1);

        // 2: short low glitch is rejected silently
        rx = 1'b0;
        repeat (50) @(negedge clock);
        rx = 1'b1;
        repeat (150) @(negedge clock);
        chk("t2/busy", int'(busy), 0);
        check_all("t2_glitch");
        send_frame(8'h3C, 1'b1, 1'b0);
        check_all("t2");

        // 3: low stop bit, line held low, then recovery
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (340) @(negedge clock);
        chk("t3/busy_low_line", int'(busy), 1);
        chk("t3/valid", int'(valid), 0);
        check_all("t3_ferr");
        rx = 1'b1;
        repeat (50) @(negedge clock);
        send_frame(8'h0F, 1'b1, 1'b0);
        check_all("t3");

        // 4: holding register full, second byte overruns
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("t4/valid", int'(valid), 1);
        chk("t4/data", int'(data), 32'h11);
        check_all("t4_hold");
        ready = 1'b1;
        model_release();
        repeat (5) @(negedge clock);
        chk("t4/valid_after", int'(valid), 0);
        check_all("t4");

        // 5: reset in the middle of data bit 4, released with the line low
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(i[0]);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("t5_reset");
        repeat (10) @(negedge clock);
        reset = 1'b0;
        repeat (400) @(negedge clock);
        chk("t5/busy_low_line", int'(busy), 1);
        check_all("t5_blocked");
        rx = 1'b1;
        repeat (50) @(negedge clock);
        send_frame(8'h81, 1'b1, 1'b0);
        check_all("t5");

`ifdef UART_RX_PARITY_EN
        // 6: even parity, wrong then right parity bit
        send_frame(8'h07, 1'b1, 1'b1);
        check_all("t6_bad");
        send_frame(8'h07, 1'b1, 1'b0);
        check_all("t6_good");
`endif

        // random frames, occasionally with a bad stop or parity bit
        for (int k = 0; k < 6; k++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            pf = PAR_EN && ($urandom_range(0, 3) == 0);
            send_frame(b, st, pf);
            if (!st) begin
                rx = 1'b1;
                repeat (30) @(negedge clock);
            end
        end
        check_all("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

endmodule
